// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: register addresses, transfer length and the
// sprite DMA sequencer state encoding.
package ppu_pkg;

    // CPU write address that starts a sprite DMA; the data byte is the source page
    localparam logic [15:0] DMA_REG  = 16'h4014;
    // OAM data port driven on the bus during every put cycle
    localparam logic [15:0] OAM_REG  = 16'h2004;
    // Bytes per transfer; a power of two no larger than one page
    localparam int          XFER_LEN = 256;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: on a CPU write to $4014 it halts the CPU, then copies
// one page into OAM as alternating get (read page byte) / put (write $2004)
// bus cycles. Everything advances only on cpu_ce.
module oam_dma_ctrl
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_dout,
    input  logic [7:0]  bus_din,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  oam_din,
    output logic        oam_wr,
    output logic        busy
);

    // Index of the final byte; idx is 8 bits so the source never leaves the page
    localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

    dma_state_t  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic        phase_q, phase_d;      // 0 = get cycle, 1 = put cycle
    logic [7:0]  oam_din_q, oam_din_d;
    logic [15:0] halt_addr_q, halt_addr_d;  // CPU address seen on the halt cycle

    logic dma_req;
    assign dma_req = !cpu_rw && (cpu_addr == DMA_REG);

    assign oam_din = oam_din_q;

    // State register: sequencer state plus index, page, parity and data latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DMA_IDLE;
            idx_q       <= '0;
            page_q      <= '0;
            phase_q     <= 1'b0;
            oam_din_q   <= '0;
            halt_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            page_q      <= page_d;
            phase_q     <= phase_d;
            oam_din_q   <= oam_din_d;
            halt_addr_q <= halt_addr_d;
        end
    end

    // Next-state decode; nothing moves unless the CPU cycle strobe is present
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        page_d      = page_q;
        phase_d     = phase_q;
        oam_din_d   = oam_din_q;
        halt_addr_d = halt_addr_q;
        if (cpu_ce) begin
            phase_d = ~phase_q;
            case (state_q)
                DMA_IDLE: begin
                    if (dma_req) begin
                        page_d  = cpu_dout;
                        idx_d   = '0;
                        state_d = DMA_HALT;
                    end
                end
                DMA_HALT: begin
                    // Only a read cycle can be stolen; writes pass through
                    if (cpu_rw) begin
                        halt_addr_d = cpu_addr;
                        // Next cycle parity is ~phase_q; a get needs no alignment
                        state_d     = phase_q ? DMA_READ : DMA_ALIGN;
                    end
                end
                DMA_ALIGN: begin
                    state_d = DMA_READ;
                end
                DMA_READ: begin
                    oam_din_d = bus_din;
                    state_d   = DMA_WRITE;
                end
                DMA_WRITE: begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == IDX_LAST) ? DMA_IDLE : DMA_READ;
                end
                default: begin
                    state_d = DMA_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state
    always_comb begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        dma_addr   = '0;
        dma_rw     = 1'b1;
        oam_wr     = 1'b0;
        busy       = 1'b0;
        case (state_q)
            DMA_HALT: begin
                cpu_rdy = 1'b0;
                busy    = 1'b1;
            end
            DMA_ALIGN: begin
                cpu_rdy    = 1'b0;
                busy       = 1'b1;
                dma_active = 1'b1;
                dma_addr   = halt_addr_q;
            end
            DMA_READ: begin
                cpu_rdy    = 1'b0;
                busy       = 1'b1;
                dma_active = 1'b1;
                dma_addr   = {page_q, idx_q};
            end
            DMA_WRITE: begin
                cpu_rdy    = 1'b0;
                busy       = 1'b1;
                dma_active = 1'b1;
                dma_addr   = OAM_REG;
                dma_rw     = 1'b0;
                oam_wr     = cpu_ce;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for the sprite DMA sequencer. A schedule-based model
// (cycles since the halt cycle -> align / get / put) predicts every output on
// every clock; directed scenarios add literal expectations on top.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_dout;
    logic [7:0]  bus_din;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  oam_din;
    logic        oam_wr;
    logic        busy;

    oam_dma_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_ce    (cpu_ce),
        .cpu_addr  (cpu_addr),
        .cpu_rw    (cpu_rw),
        .cpu_dout  (cpu_dout),
        .bus_din   (bus_din),
        .cpu_rdy   (cpu_rdy),
        .dma_active(dma_active),
        .dma_addr  (dma_addr),
        .dma_rw    (dma_rw),
        .oam_din   (oam_din),
        .oam_wr    (oam_wr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents seen on the bus: a fixed hash of the address
    function automatic logic [7:0] byte_at(input logic [15:0] a);
        logic [7:0] t;
        t = a[7:0] * 8'd37;
        return t ^ a[15:8] ^ 8'h5A;
    endfunction

    // Bus read data follows whoever owns the bus
    assign bus_din = byte_at(dma_active ? dma_addr : cpu_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ce_cnt;     // CPU cycles since reset; parity 0 = get
    bit          m_busy;       // trigger accepted, transfer not finished
    bit          m_halted;     // halt read cycle already taken
    bit          m_align;      // one alignment cycle needed
    int          m_j;          // DMA cycles elapsed after the halt cycle
    logic [7:0]  m_page;
    logic [15:0] m_halt_addr;
    logic [7:0]  m_oam_din;

    // bookkeeping from DUT observations, for literal checks
    int          busy_cyc = 0;
    int          wr_cnt   = 0;
    logic [15:0] last_rd_addr = 16'h0;
    logic [7:0]  wr_log [0:8191];

    task automatic model_reset();
        m_ce_cnt    = 0;
        m_busy      = 0;
        m_halted    = 0;
        m_align     = 0;
        m_j         = 0;
        m_page      = 8'h00;
        m_halt_addr = 16'h0000;
        m_oam_din   = 8'h00;
    endtask

    task automatic model_step();
        int n;
        if (!m_busy) begin
            if (!cpu_rw && cpu_addr == 16'h4014) begin
                m_busy   = 1;
                m_halted = 0;
                m_page   = cpu_dout;
            end
        end else if (!m_halted) begin
            if (cpu_rw) begin
                m_halted    = 1;
                m_halt_addr = cpu_addr;
                m_align     = (m_ce_cnt % 2 == 0);
                m_j         = 0;
            end
        end else begin
            n = m_j - int'(m_align);
            if (n >= 0 && n % 2 == 0)
                m_oam_din = byte_at({m_page, 8'(n / 2)});
            m_j++;
            if (m_j == int'(m_align) + 512) begin
                m_busy   = 0;
                m_halted = 0;
            end
        end
        m_ce_cnt++;
    endtask

    // Compare process: check on the falling edge, advance the model on the rising edge
    initial begin
        logic        e_rdy, e_act, e_rw, e_wr, e_busy;
        logic [15:0] e_addr;
        int          n;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            e_rdy = 1; e_act = 0; e_addr = 16'h0; e_rw = 1; e_wr = 0; e_busy = 0;
            if (m_busy) begin
                e_rdy  = 0;
                e_busy = 1;
                if (m_halted) begin
                    e_act = 1;
                    if (m_j < int'(m_align)) begin
                        e_addr = m_halt_addr;
                    end else begin
                        n = m_j - int'(m_align);
                        if (n % 2 == 0) begin
                            e_addr = {m_page, 8'(n / 2)};
                        end else begin
                            e_addr = 16'h2004;
                            e_rw   = 0;
                            e_wr   = cpu_ce;
                        end
                    end
                end
            end
            chk("cpu_rdy",    32'(cpu_rdy),    32'(e_rdy));
            chk("dma_active", 32'(dma_active), 32'(e_act));
            chk("dma_addr",   32'(dma_addr),   32'(e_addr));
            chk("dma_rw",     32'(dma_rw),     32'(e_rw));
            chk("oam_wr",     32'(oam_wr),     32'(e_wr));
            chk("busy",       32'(busy),       32'(e_busy));
            chk("oam_din",    32'(oam_din),    32'(m_oam_din));
            if (cpu_ce && busy) busy_cyc++;
            if (oam_wr) begin
                wr_log[wr_cnt % 8192] = oam_din;
                wr_cnt++;
            end
            if (dma_active && dma_rw && cpu_ce) last_rd_addr = dma_addr;
            @(posedge clk);
            if (!rst_n) model_reset();
            else if (cpu_ce) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit ce, input bit rw, input logic [15:0] a, input logic [7:0] d);
        cpu_ce   = ce;
        cpu_rw   = rw;
        cpu_addr = a;
        cpu_dout = d;
        @(posedge clk);
        #1;
    endtask

    // Random CPU cycle that is never a $4014 write
    task automatic rnd_cyc(input bit ce);
        logic [15:0] a;
        bit          rw;
        a  = 16'($urandom);
        rw = 1'($urandom);
        if (!rw && a == 16'h4014) a = 16'h4015;
        cyc(ce, rw, a, 8'($urandom));
    endtask

    task automatic align_parity(input int want);
        for (int i = 0; i < 4 && (m_ce_cnt % 2) != want; i++)
            cyc(1, 1, 16'h8000, 8'h00);
    endtask

    task automatic run_to_idle(input string name);
        for (int i = 0; i < 1200 && m_busy; i++) rnd_cyc(1);
        chk({name, "_timeout"}, 32'(m_busy), 32'(0));
    endtask

    int base_busy, base_wr;

    task automatic mark();
        base_busy = busy_cyc;
        base_wr   = wr_cnt;
    endtask

    task automatic chk_xfer(input string name, input int exp_busy, input logic [7:0] page);
        chk({name, "_busy_cycles"}, 32'(busy_cyc - base_busy), 32'(exp_busy));
        chk({name, "_wr_pulses"},   32'(wr_cnt - base_wr),     32'(256));
        chk({name, "_first_byte"},  32'(wr_log[base_wr % 8192]),         32'(byte_at({page, 8'h00})));
        chk({name, "_last_byte"},   32'(wr_log[(base_wr + 255) % 8192]), 32'(byte_at({page, 8'hFF})));
        chk({name, "_rdy_back"},    32'(cpu_rdy), 32'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; cpu_ce = 0; cpu_rw = 1; cpu_addr = 16'h0; cpu_dout = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        chk("rst_cpu_rdy",  32'(cpu_rdy),  32'(1));
        chk("rst_busy",     32'(busy),     32'(0));
        chk("rst_dma_addr", 32'(dma_addr), 32'(0));
        chk("rst_dma_rw",   32'(dma_rw),   32'(1));
        chk("rst_oam_din",  32'(oam_din),  32'(0));

        // Idle traffic, no trigger
        mark();
        for (int i = 0; i < 1000; i++) rnd_cyc(1'($urandom_range(0, 3) != 0));
        chk("idle_wr_pulses", 32'(wr_cnt - base_wr), 32'(0));
        chk("idle_cpu_rdy",   32'(cpu_rdy),    32'(1));
        chk("idle_active",    32'(dma_active), 32'(0));

        // Trigger on a get cycle, read follows: 513 busy cycles
        align_parity(0);
        mark();
        cyc(1, 0, 16'h4014, 8'h02);
        cyc(1, 1, 16'hC123, 8'h00);
        run_to_idle("get_trig");
        chk_xfer("get_trig", 513, 8'h02);

        // Trigger on a put cycle: one alignment cycle, 514 busy cycles
        align_parity(1);
        mark();
        cyc(1, 0, 16'h4014, 8'h02);
        cyc(1, 1, 16'hC456, 8'h00);
        run_to_idle("put_trig");
        chk_xfer("put_trig", 514, 8'h02);

        // Two CPU writes after the trigger pass through; halt lands on the read
        align_parity(0);
        mark();
        cyc(1, 0, 16'h4014, 8'h03);
        for (int i = 0; i < 2; i++) begin
            cpu_ce = 1; cpu_rw = 0; cpu_addr = 16'h0300 + 16'(i); cpu_dout = 8'hA0;
            @(negedge clk);
            chk("wr_pass_active", 32'(dma_active), 32'(0));
            chk("wr_pass_busy",   32'(busy),       32'(1));
            @(posedge clk);
            #1;
        end
        cyc(1, 1, 16'hD000, 8'h00);
        run_to_idle("wr_pass");
        chk_xfer("wr_pass", 515, 8'h03);

        // Retrigger while busy is ignored; reset lands after byte 0x80 is fetched
        align_parity(0);
        mark();
        cyc(1, 0, 16'h4014, 8'h02);
        cyc(1, 1, 16'hC000, 8'h00);
        cyc(1, 0, 16'h4014, 8'h33);
        for (int i = 0; i < 1000 && !(m_busy && m_halted && m_j == int'(m_align) + 257); i++)
            rnd_cyc(1);
        chk("mid_reach", 32'(m_j), 32'(257));
        rst_n = 0;
        #1;
        chk("mid_last_read",  32'(last_rd_addr), 32'(16'h0280));
        chk("mid_wr_pulses",  32'(wr_cnt - base_wr), 32'(128));
        chk("mid_rst_rdy",    32'(cpu_rdy),    32'(1));
        chk("mid_rst_active", 32'(dma_active), 32'(0));
        chk("mid_rst_busy",   32'(busy),       32'(0));
        chk("mid_rst_oam_wr", 32'(oam_wr),     32'(0));
        chk("mid_rst_oamdin", 32'(oam_din),    32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        align_parity(0);
        mark();
        cyc(1, 0, 16'h4014, 8'h44);
        cyc(1, 1, 16'hC000, 8'h00);
        run_to_idle("restart");
        chk_xfer("restart", 513, 8'h44);

        // cpu_ce gated low for 50 clocks mid-transfer
        align_parity(1);
        mark();
        cyc(1, 0, 16'h4014, 8'h05);
        cyc(1, 1, 16'hC000, 8'h00);
        for (int i = 0; i < 100; i++) rnd_cyc(1);
        for (int i = 0; i < 50; i++) cyc(0, 1'($urandom), 16'($urandom), 8'($urandom));
        run_to_idle("ce_gate");
        chk_xfer("ce_gate", 514, 8'h05);

        // Random traffic with occasional triggers and gated strobes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                cyc(1'($urandom_range(0, 3) != 0), 0, 16'h4014, 8'($urandom));
            else
                rnd_cyc(1'($urandom_range(0, 3) != 0));
        end
        run_to_idle("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
